// File: rtl/fpu_types_pkg.sv
// Shared FP16 execution-unit types: the opcode set understood by the Zhinx datapath.
package fpu_types_pkg;

    typedef enum logic [3:0] {
        FPU_FADD     = 4'd0,
        FPU_FSUB     = 4'd1,
        FPU_FMUL     = 4'd2,
        FPU_FDIV     = 4'd3,
        FPU_FSQRT    = 4'd4,
        FPU_FMIN     = 4'd5,
        FPU_FMAX     = 4'd6,
        FPU_FSGNJ    = 4'd7,
        FPU_FSGNJN   = 4'd8,
        FPU_FSGNJX   = 4'd9,
        FPU_FCVT_H_W = 4'd10,
        FPU_FCVT_W_H = 4'd11,
        FPU_FCVT_WU_H = 4'd12,
        FPU_FEQ      = 4'd13,
        FPU_FLT      = 4'd14,
        FPU_FCLASS   = 4'd15
    } fpu_opcode_t;

endpackage

// File: rtl/rv32zhinx_pkg.sv
// Issue-controller types, constants and result-formatting helpers for RV32 Zhinx.
package rv32zhinx_pkg;

    import fpu_types_pkg::*;

    localparam int unsigned XLEN                   = 32;
    localparam int unsigned FLEN                   = 16;
    localparam int unsigned RD_W                   = 5;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 64;
    localparam logic [XLEN-1:0] FP16_QNAN          = 32'h0000_7E00;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } issue_state_t;

    typedef struct packed {
        fpu_opcode_t     op;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [RD_W-1:0] rd;
    } issue_req_t;

    // Ops that write an integer (not an FP16 bit pattern) into the destination register.
    function automatic logic is_int_result(fpu_opcode_t op);
        case (op)
            FPU_FCVT_W_H, FPU_FCVT_WU_H, FPU_FEQ, FPU_FLT, FPU_FCLASS: return 1'b1;
            default:                                                  return 1'b0;
        endcase
    endfunction

    // Zhinx keeps FP16 values sign-extended (NaN-boxing is not used in the X registers).
    function automatic logic [XLEN-1:0] format_result(fpu_opcode_t op, logic [XLEN-1:0] raw);
        if (is_int_result(op)) begin
            return raw;
        end
        return {{(XLEN-FLEN){raw[FLEN-1]}}, raw[FLEN-1:0]};
    endfunction

endpackage

// File: rtl/rv32zhinx_issue_ctrl.sv
// Single-outstanding issue controller between the core and the FP16 execution unit,
// with a completion timeout that returns a canonical qNaN.
module rv32zhinx_issue_ctrl
    import fpu_types_pkg::*;
    import rv32zhinx_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic            req_valid,
    output logic            req_ready,
    input  fpu_opcode_t     req_op,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    input  logic [RD_W-1:0] req_rd,
    output logic            fpu_start,
    output fpu_opcode_t     fpu_operation,
    output logic [XLEN-1:0] fpu_a,
    output logic [XLEN-1:0] fpu_b,
    input  logic            fpu_done,
    input  logic [XLEN-1:0] fpu_out,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_data,
    output logic [RD_W-1:0] rsp_rd,
    output logic            rsp_timeout
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    issue_state_t    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    issue_req_t      cap_q, cap_d;
    logic [XLEN-1:0] rsp_data_q, rsp_data_d;
    logic            rsp_timeout_q, rsp_timeout_d;
    logic            fpu_start_q, fpu_start_d;
    logic            req_ready_q, req_ready_d;
    logic            rsp_valid_q, rsp_valid_d;

    // State and registered outputs.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            cap_q         <= '0;
            rsp_data_q    <= '0;
            rsp_timeout_q <= 1'b0;
            fpu_start_q   <= 1'b0;
            req_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cap_q         <= cap_d;
            rsp_data_q    <= rsp_data_d;
            rsp_timeout_q <= rsp_timeout_d;
            fpu_start_q   <= fpu_start_d;
            req_ready_q   <= req_ready_d;
            rsp_valid_q   <= rsp_valid_d;
        end
    end

    // Next state; done is honoured in ISSUE and WAIT only and wins over timeout.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        cap_d         = cap_q;
        rsp_data_d    = rsp_data_q;
        rsp_timeout_d = rsp_timeout_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    cap_d.op = req_op;
                    cap_d.a  = req_a;
                    cap_d.b  = req_b;
                    cap_d.rd = req_rd;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d = '0;
                if (fpu_done) begin
                    rsp_data_d    = format_result(cap_q.op, fpu_out);
                    rsp_timeout_d = 1'b0;
                    state_d       = ST_RESP;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (fpu_done) begin
                    rsp_data_d    = format_result(cap_q.op, fpu_out);
                    rsp_timeout_d = 1'b0;
                    state_d       = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rsp_data_d    = FP16_QNAN;
                    rsp_timeout_d = 1'b1;
                    state_d       = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        fpu_start_d = (state_d == ST_ISSUE);
        req_ready_d = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_RESP);
    end

    assign req_ready     = req_ready_q;
    assign fpu_start     = fpu_start_q;
    assign fpu_operation = cap_q.op;
    assign fpu_a         = cap_q.a;
    assign fpu_b         = cap_q.b;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_data      = rsp_data_q;
    assign rsp_rd        = cap_q.rd;
    assign rsp_timeout   = rsp_timeout_q;

endmodule

// File: tb/tb_rv32zhinx_issue_ctrl.sv
// Randomized self-checking bench for rv32zhinx_issue_ctrl against a transaction-level model.
module tb_rv32zhinx_issue_ctrl;

    import fpu_types_pkg::*;

    localparam int TMO = 64;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    fpu_opcode_t req_op = FPU_FADD;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic [4:0]  req_rd = '0;
    logic        fpu_start;
    fpu_opcode_t fpu_operation;
    logic [31:0] fpu_a;
    logic [31:0] fpu_b;
    logic        fpu_done = 1'b0;
    logic [31:0] fpu_out = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_rd;
    logic        rsp_timeout;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    rv32zhinx_issue_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
        .CLK(CLK), .nRST(nRST),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_rd(req_rd),
        .fpu_start(fpu_start), .fpu_operation(fpu_operation), .fpu_a(fpu_a), .fpu_b(fpu_b),
        .fpu_done(fpu_done), .fpu_out(fpu_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_rd(rsp_rd), .rsp_timeout(rsp_timeout)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    // Reference: what writeback should see for an op whose unit answers after lat cycles (lat<0: never).
    function automatic logic [31:0] model_data(fpu_opcode_t op, logic [31:0] out, int lat);
        int v;
        if (lat < 0 || lat > TMO) return 32'h0000_7E00;
        case (op)
            FPU_FCVT_W_H, FPU_FCVT_WU_H, FPU_FEQ, FPU_FLT, FPU_FCLASS: return out;
            default: begin
                v = $signed(out[15:0]);
                return v;
            end
        endcase
    endfunction

    function automatic logic model_tmo(int lat);
        return (lat < 0 || lat > TMO);
    endfunction

    function automatic int model_lat(int lat);
        return (lat < 0 || lat > TMO) ? TMO + 2 : lat + 2;
    endfunction

    // Drives one transaction end to end and reports what was observed.
    task automatic do_op(input fpu_opcode_t op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input int lat, input logic [31:0] out, input int hold,
                         output logic [31:0] o_data, output logic o_tmo, output logic [4:0] o_rd,
                         output int o_lat, output int o_starts, output int o_start_k,
                         output int o_opbad, output int o_unstable, output int o_accept);
        int k;
        int w;
        w = 0;
        fpu_done = 1'b0;
        while (!req_ready && w < 200) begin
            @(posedge CLK); #1;
            w++;
        end
        o_accept = cyc;
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_rd = rd;
        @(posedge CLK); #1;
        req_valid = 1'b0;
        req_op = fpu_opcode_t'(4'($urandom)); req_a = $urandom; req_b = $urandom; req_rd = 5'($urandom);
        k = 0; o_starts = 0; o_start_k = -1; o_opbad = 0;
        while (!rsp_valid && k < 300) begin
            if (fpu_start) begin
                o_starts++;
                if (o_start_k < 0) o_start_k = k;
            end
            if (fpu_operation !== op || fpu_a !== a || fpu_b !== b) o_opbad++;
            fpu_done = (k == lat);
            fpu_out  = (k == lat) ? out : $urandom;
            @(posedge CLK); #1;
            k++;
        end
        fpu_done = 1'b0;
        o_lat = k + 1;
        o_data = rsp_data; o_tmo = rsp_timeout; o_rd = rsp_rd;
        o_unstable = 0;
        for (int i = 0; i < hold; i++) begin
            fpu_done = 1'($urandom); fpu_out = $urandom; rsp_ready = 1'b0;
            @(posedge CLK); #1;
            if (!rsp_valid || rsp_data !== o_data || rsp_timeout !== o_tmo || rsp_rd !== o_rd || req_ready)
                o_unstable++;
        end
        fpu_done = 1'b0;
        rsp_ready = 1'b1;
        @(posedge CLK); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        req_valid = 1'b1; fpu_done = 1'b1; fpu_out = 32'hDEAD_BEEF; rsp_ready = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        checks++;
        if (req_ready !== 1'b1 || fpu_start !== 1'b0 || rsp_valid !== 1'b0 || rsp_timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: ready=%b start=%b valid=%b tmo=%b, required 1 0 0 0",
                     req_ready, fpu_start, rsp_valid, rsp_timeout);
        end
        checks++;
        if (rsp_data !== 32'h0 || rsp_rd !== 5'h0 || fpu_a !== 32'h0 || fpu_b !== 32'h0 || fpu_operation !== FPU_FADD) begin
            errors++;
            $display("FAIL reset_data: data=%h rd=%h a=%h b=%h op=%0d, required all zero",
                     rsp_data, rsp_rd, fpu_a, fpu_b, fpu_operation);
        end
        req_valid = 1'b0; fpu_done = 1'b0; rsp_ready = 1'b0;
        #2 nRST = 1'b1;
        @(posedge CLK); #1;
    endtask

    task automatic test_add();
        logic [31:0] d; logic t; logic [4:0] r;
        int l, s, sk, ob, us, acc;
        do_op(FPU_FADD, 32'h0000_3C00, 32'h0000_3C00, 5'd5, 3, 32'h0000_4000, 0,
              d, t, r, l, s, sk, ob, us, acc);
        checks++;
        if (s !== 1 || sk !== 0) begin
            errors++;
            $display("FAIL add_start: pulses=%0d first_at=%0d, required 1 at 0", s, sk);
        end
        checks++;
        if (d !== 32'h0000_4000 || t !== 1'b0 || r !== 5'd5) begin
            errors++;
            $display("FAIL add_result: data=%h tmo=%b rd=%0d, required 00004000 0 5", d, t, r);
        end
        checks++;
        if (l !== 5) begin
            errors++;
            $display("FAIL add_latency: %0d, required 5", l);
        end
        checks++;
        if (ob !== 0) begin
            errors++;
            $display("FAIL add_operands_held: %0d bad cycles, required 0", ob);
        end
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL add_return_idle: ready=%b valid=%b, required 1 0", req_ready, rsp_valid);
        end
    endtask

    task automatic test_formatting();
        fpu_opcode_t ops [4];
        logic [31:0] outs [4];
        logic [31:0] d; logic t; logic [4:0] r;
        int l, s, sk, ob, us, acc;
        ops[0] = FPU_FMUL;     outs[0] = 32'h0000_C000;
        ops[1] = FPU_FCVT_W_H; outs[1] = 32'hFFFF_8123;
        ops[2] = FPU_FEQ;      outs[2] = 32'h0000_8001;
        ops[3] = FPU_FSUB;     outs[3] = 32'h1234_7BFF;
        for (int i = 0; i < 4; i++) begin
            do_op(ops[i], $urandom, $urandom, 5'(i + 9), 1, outs[i], 0,
                  d, t, r, l, s, sk, ob, us, acc);
            checks++;
            if (d !== model_data(ops[i], outs[i], 1) || t !== 1'b0) begin
                errors++;
                $display("FAIL format_%0d: data=%h tmo=%b, required %h 0", i, d, t, model_data(ops[i], outs[i], 1));
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] d; logic t; logic [4:0] r;
        int l, s, sk, ob, us, acc;
        do_op(FPU_FDIV, $urandom, $urandom, 5'd17, 2, 32'h0000_BC00, 5,
              d, t, r, l, s, sk, ob, us, acc);
        checks++;
        if (us !== 0 || d !== 32'hFFFF_BC00 || r !== 5'd17) begin
            errors++;
            $display("FAIL backpressure: unstable=%0d data=%h rd=%0d, required 0 ffffbc00 17", us, d, r);
        end
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_release: ready=%b valid=%b, required 1 0", req_ready, rsp_valid);
        end
    endtask

    task automatic test_timeout();
        int lats [3];
        logic [31:0] d; logic t; logic [4:0] r;
        int l, s, sk, ob, us, acc, seen;
        lats[0] = -1; lats[1] = TMO; lats[2] = TMO + 1;
        for (int i = 0; i < 3; i++) begin
            do_op(FPU_FSQRT, $urandom, $urandom, 5'(20 + i), lats[i], 32'h0000_3E00, 2,
                  d, t, r, l, s, sk, ob, us, acc);
            checks++;
            if (d !== model_data(FPU_FSQRT, 32'h0000_3E00, lats[i]) || t !== model_tmo(lats[i])
                || l !== model_lat(lats[i]) || us !== 0) begin
                errors++;
                $display("FAIL timeout_%0d: data=%h tmo=%b lat=%0d unstable=%0d, required %h %b %0d 0",
                         i, d, t, l, us, model_data(FPU_FSQRT, 32'h0000_3E00, lats[i]),
                         model_tmo(lats[i]), model_lat(lats[i]));
            end
        end
        seen = 0;
        fpu_done = 1'b1; fpu_out = 32'h0000_1111;
        @(posedge CLK); #1;
        fpu_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (rsp_valid || !req_ready) seen++;
            @(posedge CLK); #1;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL late_done_idle: %0d bad cycles, required 0", seen);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        fpu_done = 1'b0;
        req_valid = 1'b1; req_op = FPU_FMUL; req_a = 32'h3C00; req_b = 32'h4000; req_rd = 5'd3;
        @(posedge CLK); #1;
        req_valid = 1'b0;
        repeat (6) begin @(posedge CLK); #1; end
        nRST = 1'b0;
        #3 nRST = 1'b1;
        fpu_done = 1'b1; fpu_out = 32'h0000_4000;
        @(posedge CLK); #1;
        fpu_done = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid || fpu_start) seen++;
            @(posedge CLK); #1;
        end
        checks++;
        if (seen !== 0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_op: bad_cycles=%0d ready=%b, required 0 1", seen, req_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] tags [$];
        logic [31:0] outs [$];
        logic [31:0] d; logic t; logic [4:0] r;
        int l, s, sk, ob, us, acc, prev;
        prev = -1;
        for (int i = 0; i < 6; i++) begin
            tags.push_back(5'($urandom));
            outs.push_back($urandom);
        end
        for (int i = 0; i < 6; i++) begin
            do_op(FPU_FMAX, $urandom, $urandom, tags[i], 0, outs[i], 0,
                  d, t, r, l, s, sk, ob, us, acc);
            checks++;
            if (r !== tags[i] || d !== model_data(FPU_FMAX, outs[i], 0) || t !== 1'b0 || l !== 2) begin
                errors++;
                $display("FAIL b2b_%0d: rd=%0d data=%h tmo=%b lat=%0d, required %0d %h 0 2",
                         i, r, d, t, l, tags[i], model_data(FPU_FMAX, outs[i], 0));
            end
            if (prev >= 0) begin
                checks++;
                if (acc - prev > 4) begin
                    errors++;
                    $display("FAIL b2b_gap_%0d: %0d cycles between accepts, required <= 4", i, acc - prev);
                end
            end
            prev = acc;
        end
    endtask

    task automatic test_random();
        fpu_opcode_t op;
        logic [31:0] out;
        logic [4:0] rd;
        int lat, hold;
        logic [31:0] d; logic t; logic [4:0] r;
        int l, s, sk, ob, us, acc;
        for (int i = 0; i < 25; i++) begin
            op   = fpu_opcode_t'(4'($urandom));
            out  = $urandom;
            rd   = 5'($urandom);
            lat  = ($urandom_range(0, 5) == 0) ? $urandom_range(60, 70) : $urandom_range(0, 6);
            hold = $urandom_range(0, 3);
            do_op(op, $urandom, $urandom, rd, lat, out, hold, d, t, r, l, s, sk, ob, us, acc);
            checks++;
            if (d !== model_data(op, out, lat) || t !== model_tmo(lat) || r !== rd) begin
                errors++;
                $display("FAIL rand_%0d_result: op=%0d lat=%0d data=%h tmo=%b rd=%0d, required %h %b %0d",
                         i, op, lat, d, t, r, model_data(op, out, lat), model_tmo(lat), rd);
            end
            checks++;
            if (l !== model_lat(lat) || s !== 1 || ob !== 0 || us !== 0) begin
                errors++;
                $display("FAIL rand_%0d_timing: lat=%0d starts=%0d opbad=%0d unstable=%0d, required %0d 1 0 0",
                         i, l, s, ob, us, model_lat(lat));
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_formatting();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv32zhinx_issue_ctrl.md
RV32ZHINX_ISSUE_CTRL -- requirements
Module: rv32zhinx_issue_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64, maximum fpu_done wait in cycles before abort.
REQ-002 CLK  input  1  rising-edge clock.
REQ-003 nRST  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  1  core presents an FP16 operation.
REQ-005 req_ready  output  1  block can accept a request.
REQ-006 req_op  input  fpu_opcode_t  operation code.
REQ-007 req_a, req_b  input  32 each  source operands from integer registers.
REQ-008 req_rd  input  5  destination register tag.
REQ-009 fpu_start  output  1  one-cycle launch pulse to the FP16 execution unit.
REQ-010 fpu_operation  output  fpu_opcode_t  registered opcode.
REQ-011 fpu_a, fpu_b  output  32 each  registered operands.
REQ-012 fpu_done  input  1  execution-unit completion strobe.
REQ-013 fpu_out  input  32  execution-unit result, valid when fpu_done=1.
REQ-014 rsp_valid  output  1  result available to writeback.
REQ-015 rsp_ready  input  1  writeback accepts the result.
REQ-016 rsp_data  output  32  write-back value.
REQ-017 rsp_rd  output  5  destination tag of the returned result.
REQ-018 rsp_timeout  output  1  response is an aborted operation.

Function
REQ-019 The FSM SHALL have states IDLE, ISSUE, WAIT, RESP.
REQ-020 req_ready SHALL be 1 only in IDLE.
REQ-021 IDLE with req_valid=1 SHALL capture req_op/a/b/rd into registers and go to ISSUE next cycle.
REQ-022 ISSUE SHALL assert fpu_start for exactly one cycle, clear the wait counter, then go to WAIT.
REQ-023 fpu_operation/fpu_a/fpu_b SHALL hold the captured values from ISSUE until leaving WAIT.
REQ-024 In WAIT, fpu_done=1 SHALL capture the result into rsp_data and move to RESP with rsp_timeout=0.
REQ-025 fpu_done=1 seen in the ISSUE cycle SHALL be treated as completion: go directly to RESP.
REQ-026 fpu_done outside ISSUE/WAIT SHALL be ignored.
REQ-027 In WAIT the counter SHALL increment each cycle. When it reaches TIMEOUT_CYCLES-1 without done, the block SHALL go to RESP with rsp_data=32'h0000_7E00 (canonical FP16 qNaN) and rsp_timeout=1.
REQ-028 Done and timeout in the same cycle SHALL resolve as done.
REQ-029 rsp_data for FP16-producing ops SHALL be fpu_out[15:0] sign-extended to 32 bits. For integer-result ops it SHALL be fpu_out unchanged.
REQ-030 RESP SHALL hold rsp_valid=1 with stable rsp_data/rsp_rd/rsp_timeout until rsp_ready=1, then return to IDLE.
REQ-031 Minimum throughput SHALL be one op per 4 cycles; latency from accept to rsp_valid SHALL be fpu latency + 2 cycles.
REQ-032 At most one operation SHALL be outstanding.

Reset
REQ-033 nRST low SHALL force IDLE, all outputs 0 (req_ready=1 after reset), and clear the counter and captured registers.
REQ-034 Reset mid-operation SHALL discard the operation without a response; a late fpu_done after reset SHALL be ignored.

Structure
REQ-035 The state enum, the default TIMEOUT_CYCLES, the qNaN constant and an is_int_result(fpu_opcode_t) classification function SHALL live in rv32zhinx_pkg.
REQ-036 fpu_opcode_t SHALL come from fpu_types_pkg.
REQ-037 No sub-module is needed; the block instantiates alongside rv32zhinx_wrapper in the FPU top.

Verification
REQ-038 Add with a=0x0000_3C00, b=0x0000_3C00 and done after 3 cycles -> fpu_start one pulse; rsp_data=0x0000_4000, rsp_timeout=0.
REQ-039 Negative FP16 result fpu_out=0x0000_C000 -> rsp_data=0xFFFF_C000.
REQ-040 rsp_ready held low 5 cycles -> rsp_valid and rsp_data stable throughout; req_ready=0 until the handshake completes.
REQ-041 No done for 64 cycles -> rsp_valid with rsp_data=0x0000_7E00, rsp_timeout=1; a done arriving later is ignored.
REQ-042 nRST asserted in WAIT, then done pulsed -> no rsp_valid; req_ready=1.
REQ-043 Back-to-back requests with done in the ISSUE cycle -> each response correct, with rd tags matching request order.
